pll_div_gen: RTL and testbench

PLL_DIV_GEN -- requirements
Module: pll_div_gen

---
 rtl/pll_div_gen.sv | 161 ++++++++++++++++
 tb/tb_pll_div_gen.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pll_div_gen.sv
// Multi-channel integer clock divider with glitch-free reconfiguration,
// phase-aligned restart and a configuration-stability lock indicator.
module pll_div_gen #(
   parameter int NUM_CH      = 8,
   parameter int DIV_W       = 16,
   parameter int LOCK_CYCLES = 64,
   localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              refclk,
   input  logic              rst_n,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [DIV_W-1:0]  cfg_div,
   input  logic [DIV_W-1:0]  cfg_phase,
   input  logic              sync,
   output logic [NUM_CH-1:0] outclk,
   output logic              locked,
   output logic              cfg_err
);

   localparam int LCNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
   localparam logic [CH_W:0] NUM_CH_L = NUM_CH[CH_W:0];

   typedef enum logic {ST_WAIT, ST_LOCKED} lock_st_t;

   logic [DIV_W-1:0]  div_q   [NUM_CH];
   logic [DIV_W-1:0]  phase_q [NUM_CH];
   logic [DIV_W-1:0]  cnt_q   [NUM_CH];
   logic [NUM_CH-1:0] outclk_p1;

   logic              pend_vld;
   logic [CH_W-1:0]   pend_ch;
   logic [DIV_W-1:0]  pend_div;
   logic [DIV_W-1:0]  pend_phase;
   logic              cfg_err_q;

   lock_st_t          lock_st, lock_st_nxt;
   logic [LCNT_W-1:0] lock_cnt, lock_cnt_nxt;

   logic              accept, bad_ch, good_acc;
   logic              tgt_en, tgt_end, apply;

   function automatic logic ch_en(input logic [DIV_W-1:0] d);
      return d >= DIV_W'(2);
   endfunction

   function automatic logic [DIV_W-1:0] fit_phase(input logic [DIV_W-1:0] p,
                                                  input logic [DIV_W-1:0] d);
      return (p >= d) ? '0 : p;
   endfunction

   // High for the first ceil(N/2) counts of the period.
   function automatic logic high_phase(input logic [DIV_W-1:0] c,
                                       input logic [DIV_W-1:0] d);
      logic [DIV_W:0] half;
      half = ({1'b0, d} + (DIV_W+1)'(1)) >> 1;
      return {1'b0, c} < half;
   endfunction

   assign accept   = cfg_valid && cfg_ready;
   assign bad_ch   = {1'b0, cfg_ch} >= NUM_CH_L;
   assign good_acc = accept && !bad_ch;

   always_comb begin
      tgt_en  = 1'b0;
      tgt_end = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (pend_ch == CH_W'(i)) begin
            tgt_en  = ch_en(div_q[i]);
            tgt_end = (cnt_q[i] == div_q[i] - DIV_W'(1));
         end
      end
   end

   // A disabled target has no period to respect; sync forces the update early.
   assign apply = pend_vld && (sync || !tgt_en || tgt_end);

   // Stage 0 -> 1: per-channel counters and registered clock outputs
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            div_q[i]   <= '0;
            phase_q[i] <= '0;
            cnt_q[i]   <= '0;
         end
         outclk_p1 <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            outclk_p1[i] <= ch_en(div_q[i]) && high_phase(cnt_q[i], div_q[i]);
            if (apply && (pend_ch == CH_W'(i))) begin
               div_q[i]   <= pend_div;
               phase_q[i] <= pend_phase;
               cnt_q[i]   <= pend_phase;
            end else if (!ch_en(div_q[i])) begin
               cnt_q[i] <= '0;
            end else if (sync) begin
               cnt_q[i] <= phase_q[i];
            end else if (cnt_q[i] == div_q[i] - DIV_W'(1)) begin
               cnt_q[i] <= '0;
            end else begin
               cnt_q[i] <= cnt_q[i] + DIV_W'(1);
            end
         end
      end
   end

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         pend_vld  <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         cfg_err_q <= accept && bad_ch;
         if (good_acc) begin
            pend_vld <= 1'b1;
         end else if (apply) begin
            pend_vld <= 1'b0;
         end
      end
   end

   // Pending payload is only meaningful while pend_vld is set.
   always_ff @(posedge refclk) begin
      if (good_acc) begin
         pend_ch    <= cfg_ch;
         pend_div   <= cfg_div;
         pend_phase <= fit_phase(cfg_phase, cfg_div);
      end
   end

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         lock_st  <= ST_WAIT;
         lock_cnt <= '0;
      end else begin
         lock_st  <= lock_st_nxt;
         lock_cnt <= lock_cnt_nxt;
      end
   end

   always_comb begin
      lock_st_nxt  = lock_st;
      lock_cnt_nxt = lock_cnt;
      if (good_acc || sync) begin
         lock_st_nxt  = ST_WAIT;
         lock_cnt_nxt = '0;
      end else if ((lock_st == ST_WAIT) && !pend_vld) begin
         if (lock_cnt == LCNT_W'(LOCK_CYCLES - 1)) begin
            lock_st_nxt = ST_LOCKED;
         end else begin
            lock_cnt_nxt = lock_cnt + LCNT_W'(1);
         end
      end
   end

   assign cfg_ready = !pend_vld;
   assign cfg_err   = cfg_err_q;
   assign outclk    = outclk_p1;
   assign locked    = (lock_st == ST_LOCKED);

endmodule

// File: tb/tb_pll_div_gen.sv
// Scoreboard bench for pll_div_gen: a cycle-indexed arithmetic model predicts
// every output after each refclk edge; a monitor compares on the falling edge.
module tb_pll_div_gen;

   localparam int NCH   = 6;
   localparam int DW    = 8;
   localparam int LOCKC = 64;

   logic           refclk    = 1'b0;
   logic           rst_n     = 1'b1;
   logic           cfg_valid = 1'b0;
   logic           cfg_ready;
   logic [2:0]     cfg_ch    = '0;
   logic [DW-1:0]  cfg_div   = '0;
   logic [DW-1:0]  cfg_phase = '0;
   logic           sync      = 1'b0;
   logic [NCH-1:0] outclk;
   logic           locked;
   logic           cfg_err;

   pll_div_gen #(.NUM_CH(NCH), .DIV_W(DW), .LOCK_CYCLES(LOCKC)) dut (
      .refclk    (refclk),
      .rst_n     (rst_n),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_div   (cfg_div),
      .cfg_phase (cfg_phase),
      .sync      (sync),
      .outclk    (outclk),
      .locked    (locked),
      .cfg_err   (cfg_err)
   );

   always #5 refclk = ~refclk;

   typedef struct packed {
      logic [NCH-1:0] clk;
      logic           lck;
      logic           rdy;
      logic           err;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Model: a channel's count is (base + edges elapsed since reload) mod div.
   int m_div[NCH], m_phase[NCH], m_base[NCH], m_t0[NCH];
   int m_pend, m_pch, m_pd, m_pp, m_stable, e_now;

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act == req) n_pass++;
      else $display("FAIL %s @%0t: actual=%0d required=%0d", name, $time, act, req);
   endtask

   function automatic void model_reset();
      for (int i = 0; i < NCH; i++) begin
         m_div[i] = 0; m_phase[i] = 0; m_base[i] = 0; m_t0[i] = e_now;
      end
      m_pend = 0; m_pch = 0; m_pd = 0; m_pp = 0; m_stable = 0;
   endfunction

   function automatic int m_cnt(input int i);
      if (m_div[i] < 2) return 0;
      return (m_base[i] + (e_now - m_t0[i])) % m_div[i];
   endfunction

   function automatic exp_t model_edge();
      exp_t x;
      int   acc, bad, good, app, v_div, v_ph;
      x     = '0;
      v_div = int'(cfg_div);
      v_ph  = int'(cfg_phase);
      acc   = int'(cfg_valid) & int'(m_pend == 0);
      bad   = acc & int'(int'(cfg_ch) >= NCH);
      good  = acc & int'(bad == 0);
      for (int i = 0; i < NCH; i++)
         x.clk[i] = (m_div[i] >= 2) && (m_cnt(i) < (m_div[i] + 1) / 2);
      app = 0;
      if (m_pend != 0)
         app = int'(sync || (m_div[m_pch] < 2) || (m_cnt(m_pch) == m_div[m_pch] - 1));
      for (int i = 0; i < NCH; i++) begin
         if ((app != 0) && (i == m_pch)) begin
            m_div[i] = m_pd; m_phase[i] = m_pp; m_base[i] = m_pp; m_t0[i] = e_now + 1;
         end else if (sync && (m_div[i] >= 2)) begin
            m_base[i] = m_phase[i]; m_t0[i] = e_now + 1;
         end
      end
      if ((good != 0) || sync) m_stable = 0;
      else if (m_pend == 0) m_stable++;
      if (good != 0) begin
         m_pend = 1; m_pch = int'(cfg_ch); m_pd = v_div;
         m_pp = (v_ph >= v_div) ? 0 : v_ph;
      end else if (app != 0) begin
         m_pend = 0;
      end
      e_now++;
      x.lck = (m_stable >= LOCKC);
      x.rdy = (m_pend == 0);
      x.err = (bad != 0);
      return x;
   endfunction

   task automatic step(input int v, input int ch, input int d, input int p, input int s);
      exp_t x;
      cfg_valid = (v != 0);
      cfg_ch    = 3'(ch);
      cfg_div   = DW'(d);
      cfg_phase = DW'(p);
      sync      = (s != 0);
      x = model_edge();
      @(posedge refclk);
      exp_q.push_back(x);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0);
   endtask

   task automatic cfg_write(input int ch, input int d, input int p);
      int guard;
      guard = 0;
      while ((m_pend != 0) && (guard < 300)) begin
         step(0, 0, 0, 0, 0);
         guard++;
      end
      step(1, ch, d, p, 0);
   endtask

   task automatic do_reset();
      @(negedge refclk);
      #1;
      cfg_valid = 1'b0;
      sync      = 1'b0;
      rst_n     = 1'b0;
      #1;
      check("async_rst_outclk", int'(outclk), 0);
      check("async_rst_locked", int'(locked), 0);
      check("async_rst_ready", int'(cfg_ready), 1);
      check("async_rst_err", int'(cfg_err), 0);
      model_reset();
      repeat (3) @(posedge refclk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin : monitor
      exp_t x;
      forever begin
         @(negedge refclk);
         if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            check("outclk", int'(outclk), int'(x.clk));
            check("locked", int'(locked), int'(x.lck));
            check("cfg_ready", int'(cfg_ready), int'(x.rdy));
            check("cfg_err", int'(cfg_err), int'(x.err));
         end
      end
   end

   initial begin : driver
      int rv, rch, rd, rp, rs;
      e_now = 0;
      model_reset();
      #1 rst_n = 1'b0;
      #1;
      check("rst_outclk", int'(outclk), 0);
      check("rst_locked", int'(locked), 0);
      check("rst_ready", int'(cfg_ready), 1);
      check("rst_err", int'(cfg_err), 0);
      repeat (2) @(posedge refclk);
      #1 rst_n = 1'b1;

      idle(70);
      cfg_write(0, 4, 0);
      cfg_write(1, 5, 2);
      idle(80);
      idle(1);
      cfg_write(0, 6, 0);
      idle(30);
      cfg_write(7, 4, 7);
      idle(3);
      cfg_write(2, 4, 7);
      idle(20);
      cfg_write(0, 3, 0);
      cfg_write(1, 6, 0);
      idle(10);
      step(0, 0, 0, 0, 1);
      idle(80);
      cfg_write(1, 7, 3);
      step(0, 0, 0, 0, 1);
      idle(20);
      cfg_write(0, 10, 0);
      do_reset();
      idle(10);
      cfg_write(4, 2, 1);
      idle(10);

      for (int k = 0; k < 2400; k++) begin
         if (k == 1200) do_reset();
         if ((k % 600) == 599) idle(70);
         rv  = int'($urandom_range(0, 7) == 0);
         rch = int'($urandom_range(0, 7));
         rd  = int'($urandom_range(0, 12));
         rp  = int'($urandom_range(0, 15));
         rs  = int'($urandom_range(0, 59) == 0);
         step(rv, rch, rd, rp, rs);
      end
      idle(70);

      @(negedge refclk);
      #1;
      check("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
